// File: rtl/seg_pkg.sv
// Shared constants for the six-digit seven-segment scanner.
// All segment codes are active-low {dp,g,f,e,d,c,b,a} with the dp bit off.
package seg_pkg;

  localparam int DIG_NUM = 6;
  localparam logic [2:0] LAST_IDX = 3'(DIG_NUM - 1);

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;

  localparam logic [5:0] SEL_OFF = 6'b111111;

endpackage

// File: rtl/seg_decode.sv
// BCD to active-low seven-segment decoder (no decimal point).
// Non-BCD codes 10-15 display an "E" so bad upstream data is visible.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup from digit value to segment pattern
  always_comb begin
    seg = SEG_E[6:0];
    case (bcd)
      4'd0:    seg = SEG_0[6:0];
      4'd1:    seg = SEG_1[6:0];
      4'd2:    seg = SEG_2[6:0];
      4'd3:    seg = SEG_3[6:0];
      4'd4:    seg = SEG_4[6:0];
      4'd5:    seg = SEG_5[6:0];
      4'd6:    seg = SEG_6[6:0];
      4'd7:    seg = SEG_7[6:0];
      4'd8:    seg = SEG_8[6:0];
      4'd9:    seg = SEG_9[6:0];
      default: seg = SEG_E[6:0];
    endcase
  end

endmodule

// File: rtl/seg_dynamic_scan.sv
// Time-multiplexed driver for a 6-digit common-anode seven-segment display.
// Data is captured once per frame so a frame never mixes old and new values;
// leading zeros are blanked and a minus sign sits just left of the top digit.
module seg_dynamic_scan
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_MAX   = 16'd49_999,
  parameter logic [15:0] BLANK_CYC = 16'd50
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] unit,
  input  logic [3:0] ten,
  input  logic [3:0] hun,
  input  logic [3:0] tho,
  input  logic [3:0] ten_tho,
  input  logic [3:0] hun_hun,
  input  logic       sign,
  input  logic [5:0] point,
  input  logic       seg_en,
  output logic [5:0] sel,
  output logic [7:0] seg
);

  logic [15:0]                  cnt;
  logic [2:0]                   idx;
  logic [DIG_NUM-1:0][3:0]      snap_dig;
  logic                         snap_sign;
  logic [DIG_NUM-1:0]           snap_point;
  logic                         slot_end;
  logic                         frame_end;
  logic [2:0]                   msd;
  logic [3:0]                   cur_dig;
  logic [6:0]                   dig_seg;
  logic [6:0]                   body_seg;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == LAST_IDX);
  assign cur_dig   = snap_dig[idx];

  // Slot counter and digit index: one slot per digit, index wraps after digit 5
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Capture all display data at the very end of a frame
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      snap_dig   <= '0;
      snap_sign  <= 1'b0;
      snap_point <= '0;
    end else if (frame_end) begin
      snap_dig   <= {hun_hun, ten_tho, tho, hun, ten, unit};
      snap_sign  <= sign;
      snap_point <= point;
    end
  end

  // Highest non-zero digit; stays 0 for an all-zero value so digit 0 still shows
  always_comb begin
    if      (snap_dig[5] != 4'd0) msd = 3'd5;
    else if (snap_dig[4] != 4'd0) msd = 3'd4;
    else if (snap_dig[3] != 4'd0) msd = 3'd3;
    else if (snap_dig[2] != 4'd0) msd = 3'd2;
    else if (snap_dig[1] != 4'd0) msd = 3'd1;
    else                          msd = 3'd0;
  end

  seg_decode u_decode (
    .bcd (cur_dig),
    .seg (dig_seg)
  );

  // Choose digit, minus sign or blank for the current position
  always_comb begin
    body_seg = SEG_BLANK[6:0];
    if (idx <= msd) begin
      body_seg = dig_seg;
    end else if (snap_sign && (msd != LAST_IDX) && (idx == msd + 3'd1)) begin
      body_seg = SEG_MINUS[6:0];
    end
  end

  // Registered pin drivers with a dark gap at the start of every slot
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel <= SEL_OFF;
      seg <= SEG_BLANK;
    end else if (!seg_en || (cnt < BLANK_CYC)) begin
      sel <= SEL_OFF;
      seg <= SEG_BLANK;
    end else begin
      sel <= ~(6'b1 << idx);
      seg <= {~snap_point[idx], body_seg};
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Directed testbench for seg_dynamic_scan with short slots (10 cycles, 2 dark).
// Position in the scan is tracked by counting clock edges since reset release.
module tb_seg_dynamic_scan;

  logic       sys_clk;
  logic       sys_rst;
  logic [3:0] unit, ten, hun, tho, ten_tho, hun_hun;
  logic       sign;
  logic [5:0] point;
  logic       seg_en;
  logic [5:0] sel;
  logic [7:0] seg;

  int checks;
  int failures;
  int edges;

  logic [5:0] sel_tab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  seg_dynamic_scan #(
    .CNT_MAX   (16'd9),
    .BLANK_CYC (16'd2)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .unit    (unit),
    .ten     (ten),
    .hun     (hun),
    .tho     (tho),
    .ten_tho (ten_tho),
    .hun_hun (hun_hun),
    .sign    (sign),
    .point   (point),
    .seg_en  (seg_en),
    .sel     (sel),
    .seg     (seg)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      edges++;
    end
  endtask

  // Advance until the outputs reflect counter value 'off' of digit slot 'dig'
  task automatic wait_slot(input int dig, input int off);
    int target;
    target = 10 * dig + off;
    tick(1);
    while (((edges + 59) % 60) != target) tick(1);
  endtask

  task automatic set_value(input logic [23:0] v, input logic s, input logic [5:0] p);
    hun_hun = v[23:20];
    ten_tho = v[19:16];
    tho     = v[15:12];
    hun     = v[11:8];
    ten     = v[7:4];
    unit    = v[3:0];
    sign    = s;
    point   = p;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    seg_en  = 1'b1;
    set_value(24'h000000, 1'b0, 6'b000000);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    edges   = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sel !== 6'h3F || seg !== 8'hFF) begin
        failures++;
        $display("[TB] FAIL reset_dark_%0d: sel=%h seg=%h expected sel=3F seg=FF", k, sel, seg);
      end
      tick(1);
    end
    checks++;
    if (sel !== 6'h3E || seg !== 8'hC0) begin
      failures++;
      $display("[TB] FAIL reset_digit0: sel=%h seg=%h expected sel=3E seg=C0", sel, seg);
    end
    for (int i = 1; i < 6; i++) begin
      wait_slot(i, 5);
      checks++;
      if (sel !== sel_tab[i] || seg !== 8'hFF) begin
        failures++;
        $display("[TB] FAIL reset_blank_d%0d: sel=%h seg=%h expected sel=%h seg=FF", i, sel, seg, sel_tab[i]);
      end
    end
  endtask

  task automatic test_plain();
    logic [7:0] exp_seg [6];
    exp_seg = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    set_value(24'h123456, 1'b0, 6'b000000);
    wait_slot(5, 9);
    for (int i = 0; i < 6; i++) begin
      wait_slot(i, 5);
      checks++;
      if (sel !== sel_tab[i] || seg !== exp_seg[i]) begin
        failures++;
        $display("[TB] FAIL plain_d%0d: sel=%h seg=%h expected sel=%h seg=%h", i, sel, seg, sel_tab[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_full_negative();
    set_value(24'h999999, 1'b1, 6'b000000);
    wait_slot(5, 9);
    for (int i = 0; i < 6; i++) begin
      wait_slot(i, 5);
      checks++;
      if (sel !== sel_tab[i] || seg !== 8'h90) begin
        failures++;
        $display("[TB] FAIL full_neg_d%0d: sel=%h seg=%h expected sel=%h seg=90", i, sel, seg, sel_tab[i]);
      end
    end
  endtask

  task automatic test_minus();
    logic [7:0] exp_seg [6];
    exp_seg = '{8'h82, 8'h92, 8'h99, 8'hBF, 8'hFF, 8'hFF};
    set_value(24'h000456, 1'b1, 6'b000000);
    wait_slot(5, 9);
    for (int i = 0; i < 6; i++) begin
      wait_slot(i, 5);
      checks++;
      if (sel !== sel_tab[i] || seg !== exp_seg[i]) begin
        failures++;
        $display("[TB] FAIL minus_d%0d: sel=%h seg=%h expected sel=%h seg=%h", i, sel, seg, sel_tab[i], exp_seg[i]);
      end
    end
  endtask

  // Negative zero with a dp on the minus digit, then a non-BCD code
  task automatic test_boundaries();
    logic [7:0] exp_seg [3];
    exp_seg = '{8'hC0, 8'h3F, 8'hFF};
    set_value(24'h000000, 1'b1, 6'b000010);
    wait_slot(5, 9);
    for (int i = 0; i < 3; i++) begin
      wait_slot(i, 5);
      checks++;
      if (sel !== sel_tab[i] || seg !== exp_seg[i]) begin
        failures++;
        $display("[TB] FAIL neg_zero_d%0d: sel=%h seg=%h expected sel=%h seg=%h", i, sel, seg, sel_tab[i], exp_seg[i]);
      end
    end
    set_value(24'h00000C, 1'b0, 6'b000000);
    wait_slot(5, 9);
    wait_slot(0, 5);
    checks++;
    if (sel !== 6'h3E || seg !== 8'h86) begin
      failures++;
      $display("[TB] FAIL invalid_code: sel=%h seg=%h expected sel=3E seg=86", sel, seg);
    end
    wait_slot(1, 5);
    checks++;
    if (sel !== 6'h3D || seg !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL invalid_blank: sel=%h seg=%h expected sel=3D seg=FF", sel, seg);
    end
  endtask

  task automatic test_mid_frame();
    logic [7:0] old_seg [6];
    logic [7:0] new_seg [6];
    old_seg = '{8'h82, 8'h92, 8'h99, 8'hF8, 8'h80, 8'h90};
    new_seg = '{8'h82, 8'hC0, 8'hF9, 8'hF9, 8'h80, 8'h90};
    set_value(24'h987654, 1'b0, 6'b000000);
    wait_slot(5, 9);
    wait_slot(3, 5);
    set_value(24'h981106, 1'b0, 6'b000000);
    for (int i = 3; i < 6; i++) begin
      if (i > 3) wait_slot(i, 5);
      checks++;
      if (sel !== sel_tab[i] || seg !== old_seg[i]) begin
        failures++;
        $display("[TB] FAIL mid_old_d%0d: sel=%h seg=%h expected sel=%h seg=%h", i, sel, seg, sel_tab[i], old_seg[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      wait_slot(i, 5);
      checks++;
      if (sel !== sel_tab[i] || seg !== new_seg[i]) begin
        failures++;
        $display("[TB] FAIL mid_new_d%0d: sel=%h seg=%h expected sel=%h seg=%h", i, sel, seg, sel_tab[i], new_seg[i]);
      end
    end
  endtask

  task automatic test_point_enable();
    set_value(24'h123456, 1'b0, 6'b000100);
    wait_slot(5, 9);
    wait_slot(2, 5);
    checks++;
    if (sel !== 6'h3B || seg !== 8'h19) begin
      failures++;
      $display("[TB] FAIL point_d2: sel=%h seg=%h expected sel=3B seg=19", sel, seg);
    end
    wait_slot(3, 5);
    checks++;
    if (sel !== 6'h37 || seg !== 8'hB0) begin
      failures++;
      $display("[TB] FAIL point_d3: sel=%h seg=%h expected sel=37 seg=B0", sel, seg);
    end
    seg_en = 1'b0;
    tick(1);
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL disable_next: sel=%h seg=%h expected sel=3F seg=FF", sel, seg);
    end
    wait_slot(4, 5);
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL disable_d4: sel=%h seg=%h expected sel=3F seg=FF", sel, seg);
    end
    wait_slot(5, 5);
    seg_en = 1'b1;
    tick(1);
    checks++;
    if (sel !== 6'h1F || seg !== 8'hF9) begin
      failures++;
      $display("[TB] FAIL enable_d5: sel=%h seg=%h expected sel=1F seg=F9", sel, seg);
    end
  endtask

  task automatic test_reset_mid();
    wait_slot(4, 5);
    checks++;
    if (sel !== 6'h2F || seg !== 8'hA4) begin
      failures++;
      $display("[TB] FAIL pre_reset_d4: sel=%h seg=%h expected sel=2F seg=A4", sel, seg);
    end
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL async_reset: sel=%h seg=%h expected sel=3F seg=FF", sel, seg);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    edges   = 0;
    tick(2);
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL restart_dark: sel=%h seg=%h expected sel=3F seg=FF", sel, seg);
    end
    tick(1);
    checks++;
    if (sel !== 6'h3E || seg !== 8'hC0) begin
      failures++;
      $display("[TB] FAIL restart_d0: sel=%h seg=%h expected sel=3E seg=C0", sel, seg);
    end
    wait_slot(1, 5);
    checks++;
    if (sel !== 6'h3D || seg !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL restart_d1: sel=%h seg=%h expected sel=3D seg=FF", sel, seg);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    checks   = 0;
    failures = 0;
    edges    = 0;
    test_reset();
    test_plain();
    test_full_negative();
    test_minus();
    test_boundaries();
    test_mid_frame();
    test_point_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
